// File: rtl/sum_arb_ctrl.sv
// Two-requester round-robin arbiter feeding a per-channel sliding-window adder (window 1..4).
// Defining SUM_FLUSH_EN adds a 2-bit flush input that zeroes a channel's sample history.
module sum_arb_ctrl #(
    parameter int DW = 8,
    parameter int OW = DW + 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic [1:0]    win_len,
`ifdef SUM_FLUSH_EN
    input  logic [1:0]    flush,
`endif
    output logic [OW-1:0] out,
    output logic          out_ch,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       sample_q, sample_d;
    logic                ch_q, ch_d;
    logic [1:0]          len_q, len_d;
    logic [OW-1:0]       out_q, out_d;
    logic                out_ch_q, out_ch_d;
    logic                out_valid_q, out_valid_d;
    logic                last_q, last_d;

    logic [1:0]          flush_w;
    logic                grant_a;
    logic                grant_b;
    logic [1:0][2:0][DW-1:0] hist_all;
    logic [2:0][DW-1:0]  hist_sel;
    logic [OW-1:0]       window_sum;

`ifdef SUM_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 2'b00;
`endif

    // last_q = 1 means B was served last, so A wins the next tie.
    assign grant_b = b_valid && (!a_valid || !last_q);
    assign grant_a = a_valid && !grant_b;

    // Per-channel history, index 0 is the newest sample.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hist
            logic [2:0][DW-1:0] hist_q, hist_d;

            always_comb begin
                hist_d = hist_q;
                if (flush_w[gi]) begin
                    hist_d = '0;
                end
                if (state_q == SUM && ch_q == 1'(gi)) begin
                    hist_d = {hist_d[1:0], sample_q};
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    hist_q <= '0;
                end else begin
                    hist_q <= hist_d;
                end
            end

            assign hist_all[gi] = hist_q;
        end
    endgenerate

    // A flush landing on the summing edge takes effect before the add.
    always_comb begin
        hist_sel   = flush_w[ch_q] ? '0 : hist_all[ch_q];
        window_sum = OW'(sample_q);
        if (len_q != 2'd1) begin
            window_sum = window_sum + OW'(hist_sel[0]);
        end
        if (len_q == 2'd0 || len_q == 2'd3) begin
            window_sum = window_sum + OW'(hist_sel[1]);
        end
        if (len_q == 2'd0) begin
            window_sum = window_sum + OW'(hist_sel[2]);
        end
    end

    always_comb begin
        state_d     = state_q;
        sample_d    = sample_q;
        ch_d        = ch_q;
        len_d       = len_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        last_d      = last_q;
        a_ready     = 1'b0;
        b_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                if (reset) begin
                    a_ready = grant_a;
                    b_ready = grant_b;
                end
                if (grant_a || grant_b) begin
                    state_d  = SUM;
                    sample_d = grant_b ? b_data : a_data;
                    ch_d     = grant_b;
                    len_d    = win_len;
                    last_d   = grant_b;
                end
            end
            SUM: begin
                out_d       = window_sum;
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sample_q    <= '0;
            ch_q        <= 1'b0;
            len_q       <= 2'd0;
            out_q       <= '0;
            out_ch_q    <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            ch_q        <= ch_d;
            len_q       <= len_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
